// File: rtl/mist1032isa_sync_edge_detector.sv
// Multi-channel edge-event detector: synchroniser, debounce filter, edge qualifier,
// one-cycle event strobe and sticky pending/overrun flags with software clear.
module mist1032isa_sync_edge_detector #(
    parameter int          N             = 1,
    parameter int          SYNC_STAGES   = 2,
    parameter int          FILTER_CYCLES = 1,
    parameter logic [N-1:0] INIT         = '0
) (
    input  logic           iCLOCK,
    input  logic           inRESET,
    input  logic [N-1:0]   iSIGNAL,
    input  logic [2*N-1:0] iMODE,
    input  logic [N-1:0]   iCLEAR,
    output logic [N-1:0]   oLEVEL,
    output logic [N-1:0]   oPULSE,
    output logic [N-1:0]   oPENDING,
    output logic [N-1:0]   oOVERRUN
);

    localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be in 2..4");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter_cycles
        $error("FILTER_CYCLES must be in 1..255");
    end

    logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
    logic [N-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [N-1:0]                  level_q, level_d;
    logic [N-1:0]                  pulse_q, pulse_d;
    logic [N-1:0]                  pending_q, pending_d;
    logic [N-1:0]                  overrun_q, overrun_d;
    logic [N-1:0]                  sync_s;
    logic [N-1:0]                  flip;
    logic [N-1:0]                  ev;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], iSIGNAL};
        sync_s    = sync_q[SYNC_STAGES-1];
        cnt_d     = cnt_q;
        level_d   = level_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        flip      = '0;
        ev        = '0;
        for (int i = 0; i < N; i++) begin
            // The level only flips after FILTER_CYCLES consecutive disagreeing samples.
            if (sync_s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = sync_s[i];
                cnt_d[i]   = '0;
                flip[i]    = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            ev[i] = (flip[i] &  sync_s[i] & iMODE[2*i])
                  | (flip[i] & ~sync_s[i] & iMODE[2*i+1]);

            // A new event beats a simultaneous clear and leaves overrun cleared.
            if (ev[i]) begin
                pending_d[i] = 1'b1;
                if (iCLEAR[i]) begin
                    overrun_d[i] = 1'b0;
                end else if (pending_q[i]) begin
                    overrun_d[i] = 1'b1;
                end
            end else if (iCLEAR[i]) begin
                pending_d[i] = 1'b0;
                overrun_d[i] = 1'b0;
            end
        end
        pulse_d = ev;
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            sync_q    <= {SYNC_STAGES{INIT}};
            cnt_q     <= '0;
            level_q   <= INIT;
            pulse_q   <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign oLEVEL   = level_q;
    assign oPULSE   = pulse_q;
    assign oPENDING = pending_q;
    assign oOVERRUN = overrun_q;

endmodule

// File: tb/tb_mist1032isa_sync_edge_detector.sv
// Directed bench: dut_a has default filtering (4 channels), dut_b filters over 4 cycles.
module tb_mist1032isa_sync_edge_detector;

    logic       clk = 1'b0;
    logic       rst_a_n, rst_b_n;
    logic [3:0] sig_a, clr_a, lvl_a, pls_a, pnd_a, ovr_a;
    logic [7:0] mode_a;
    logic [3:0] sig_b, clr_b, lvl_b, pls_b, pnd_b, ovr_b;
    logic [7:0] mode_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    mist1032isa_sync_edge_detector #(.N(4), .SYNC_STAGES(2), .FILTER_CYCLES(1), .INIT(4'b0000)) dut_a (
        .iCLOCK(clk), .inRESET(rst_a_n), .iSIGNAL(sig_a), .iMODE(mode_a), .iCLEAR(clr_a),
        .oLEVEL(lvl_a), .oPULSE(pls_a), .oPENDING(pnd_a), .oOVERRUN(ovr_a)
    );

    mist1032isa_sync_edge_detector #(.N(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .INIT(4'b0000)) dut_b (
        .iCLOCK(clk), .inRESET(rst_b_n), .iSIGNAL(sig_b), .iMODE(mode_b), .iCLEAR(clr_b),
        .oLEVEL(lvl_b), .oPULSE(pls_b), .oPENDING(pnd_b), .oOVERRUN(ovr_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        sig_a = '0; clr_a = '0; mode_a = 8'b01010101;
        sig_b = '0; clr_b = '0; mode_b = 8'b01010101;
        repeat (3) tick();
        checks++;
        if ({lvl_a, pls_a, pnd_a, ovr_a} !== 16'h0) begin
            errors++; $display("FAIL reset_a: got %h expected 0000", {lvl_a, pls_a, pnd_a, ovr_a});
        end
        checks++;
        if ({lvl_b, pls_b, pnd_b, ovr_b} !== 16'h0) begin
            errors++; $display("FAIL reset_b: got %h expected 0000", {lvl_b, pls_b, pnd_b, ovr_b});
        end
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_rise();
        sig_a[0] = 1'b1;
        tick(); tick();
        checks++;
        if (lvl_a[0] !== 1'b0 || pls_a[0] !== 1'b0) begin
            errors++; $display("FAIL basic_early: level=%b pulse=%b expected 0 0", lvl_a[0], pls_a[0]);
        end
        tick();
        checks++;
        if ({lvl_a[0], pls_a[0], pnd_a[0], ovr_a[0]} !== 4'b1110) begin
            errors++; $display("FAIL basic_edge: lvl/pls/pnd/ovr=%b expected 1110",
                               {lvl_a[0], pls_a[0], pnd_a[0], ovr_a[0]});
        end
        tick();
        checks++;
        if ({lvl_a[0], pls_a[0], pnd_a[0], ovr_a[0]} !== 4'b1010) begin
            errors++; $display("FAIL basic_after: lvl/pls/pnd/ovr=%b expected 1010",
                               {lvl_a[0], pls_a[0], pnd_a[0], ovr_a[0]});
        end
        clr_a = 4'b0001;
        tick();
        clr_a = '0;
        checks++;
        if (pnd_a[0] !== 1'b0) begin
            errors++; $display("FAIL basic_clear: pending=%b expected 0", pnd_a[0]);
        end
    endtask

    task automatic test_mode_sweep();
        logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        int         exp_r [4] = '{1, 0, 1, 0};
        int         exp_f [4] = '{0, 1, 1, 0};
        for (int m = 0; m < 4; m++) begin
            int   rc = 0;
            int   fc = 0;
            logic saw_high = 1'b0;
            mode_a[3:2] = modes[m];
            tick();
            if (pls_a[1]) rc++;
            sig_a[1] = 1'b1;
            for (int t = 0; t < 5; t++) begin
                tick();
                if (pls_a[1]) rc++;
                saw_high |= lvl_a[1];
            end
            sig_a[1] = 1'b0;
            for (int t = 0; t < 5; t++) begin
                tick();
                if (pls_a[1]) fc++;
            end
            checks++;
            if (rc != exp_r[m] || fc != exp_f[m]) begin
                errors++; $display("FAIL mode_sweep_pulses mode=%b: rise=%0d fall=%0d expected %0d %0d",
                                   modes[m], rc, fc, exp_r[m], exp_f[m]);
            end
            checks++;
            if (saw_high !== 1'b1 || lvl_a[1] !== 1'b0) begin
                errors++; $display("FAIL mode_sweep_level mode=%b: saw_high=%b final=%b expected 1 0",
                                   modes[m], saw_high, lvl_a[1]);
            end
        end
    endtask

    task automatic test_overrun();
        mode_a[5:4] = 2'b11;
        clr_a = 4'hF; tick(); clr_a = '0;
        sig_a[2] = 1'b1; repeat (4) tick();
        checks++;
        if ({pnd_a[2], ovr_a[2]} !== 2'b10) begin
            errors++; $display("FAIL overrun_first: pnd/ovr=%b expected 10", {pnd_a[2], ovr_a[2]});
        end
        sig_a[2] = 1'b0; repeat (4) tick();
        checks++;
        if ({pnd_a[2], ovr_a[2]} !== 2'b11) begin
            errors++; $display("FAIL overrun_second: pnd/ovr=%b expected 11", {pnd_a[2], ovr_a[2]});
        end
        clr_a[2] = 1'b1; tick(); clr_a = '0;
        checks++;
        if ({pnd_a[2], ovr_a[2]} !== 2'b00) begin
            errors++; $display("FAIL overrun_clear: pnd/ovr=%b expected 00", {pnd_a[2], ovr_a[2]});
        end
    endtask

    task automatic test_clear_collision();
        sig_a[2] = 1'b1; repeat (4) tick();
        sig_a[2] = 1'b0; repeat (4) tick();
        checks++;
        if (ovr_a[2] !== 1'b1) begin
            errors++; $display("FAIL collision_setup: overrun=%b expected 1", ovr_a[2]);
        end
        sig_a[2] = 1'b1;
        tick(); tick();
        clr_a[2] = 1'b1;
        tick();
        clr_a = '0;
        checks++;
        if ({pls_a[2], pnd_a[2], ovr_a[2]} !== 3'b110) begin
            errors++; $display("FAIL collision_edge: pls/pnd/ovr=%b expected 110",
                               {pls_a[2], pnd_a[2], ovr_a[2]});
        end
        tick();
        checks++;
        if ({pls_a[2], pnd_a[2], ovr_a[2]} !== 3'b010) begin
            errors++; $display("FAIL collision_hold: pls/pnd/ovr=%b expected 010",
                               {pls_a[2], pnd_a[2], ovr_a[2]});
        end
    endtask

    task automatic test_multi_channel();
        rst_a_n = 1'b0; sig_a = '0; clr_a = '0;
        mode_a = 8'b11_10_01_00;
        repeat (2) tick();
        rst_a_n = 1'b1;
        checks++;
        if ({lvl_a, pls_a, pnd_a, ovr_a} !== 16'h0) begin
            errors++; $display("FAIL multi_reset: got %h expected 0000", {lvl_a, pls_a, pnd_a, ovr_a});
        end
        sig_a = 4'hF;
        tick(); tick();
        checks++;
        if (pls_a !== 4'b0000) begin
            errors++; $display("FAIL multi_early: pulse=%b expected 0000", pls_a);
        end
        tick();
        checks++;
        if (pls_a !== 4'b1010 || lvl_a !== 4'b1111) begin
            errors++; $display("FAIL multi_rise: pulse=%b level=%b expected 1010 1111", pls_a, lvl_a);
        end
        sig_a = 4'h0;
        repeat (3) tick();
        checks++;
        if (pls_a !== 4'b1100 || lvl_a !== 4'b0000) begin
            errors++; $display("FAIL multi_fall: pulse=%b level=%b expected 1100 0000", pls_a, lvl_a);
        end
        tick();
        checks++;
        if (pnd_a !== 4'b1110 || ovr_a !== 4'b1000 || pls_a !== 4'b0000) begin
            errors++; $display("FAIL multi_flags: pnd=%b ovr=%b pls=%b expected 1110 1000 0000",
                               pnd_a, ovr_a, pls_a);
        end
    endtask

    task automatic test_glitch_filter();
        int   pc = 0;
        logic seen = 1'b0;
        sig_b[0] = 1'b1; repeat (3) tick();
        sig_b[0] = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            seen |= lvl_b[0] | pls_b[0] | pnd_b[0];
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL glitch_3cyc: level/pulse/pending seen=%b expected 0", seen);
        end
        sig_b[0] = 1'b1; repeat (4) tick();
        sig_b[0] = 1'b0;
        tick();
        checks++;
        if (lvl_b[0] !== 1'b0) begin
            errors++; $display("FAIL glitch_4cyc_early: level=%b expected 0", lvl_b[0]);
        end
        tick();
        checks++;
        if (lvl_b[0] !== 1'b1 || pls_b[0] !== 1'b1) begin
            errors++; $display("FAIL glitch_4cyc_edge: level=%b pulse=%b expected 1 1", lvl_b[0], pls_b[0]);
        end
        for (int t = 0; t < 10; t++) begin
            tick();
            if (pls_b[0]) pc++;
        end
        checks++;
        if (pc != 0 || lvl_b[0] !== 1'b0) begin
            errors++; $display("FAIL glitch_4cyc_after: extra_pulses=%0d level=%b expected 0 0", pc, lvl_b[0]);
        end
    endtask

    task automatic test_reset_mid_filter();
        int stray = 0;
        mode_b = 8'b01_11_10_01;
        sig_b  = 4'b0100;
        repeat (4) tick();
        rst_b_n = 1'b0;
        tick();
        checks++;
        if ({lvl_b, pls_b, pnd_b, ovr_b} !== 16'h0) begin
            errors++; $display("FAIL midreset_state: got %h expected 0000", {lvl_b, pls_b, pnd_b, ovr_b});
        end
        rst_b_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (pls_b != 4'b0000) stray++;
        end
        checks++;
        if (stray != 0 || lvl_b !== 4'b0000) begin
            errors++; $display("FAIL midreset_restart: stray=%0d level=%b expected 0 0000", stray, lvl_b);
        end
        tick();
        checks++;
        if (lvl_b !== 4'b0100 || pls_b !== 4'b0100 || pnd_b !== 4'b0100) begin
            errors++; $display("FAIL midreset_event: level=%b pulse=%b pending=%b expected 0100 0100 0100",
                               lvl_b, pls_b, pnd_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic_rise();
        test_mode_sweep();
        test_overrun();
        test_clear_collision();
        test_multi_channel();
        test_glitch_filter();
        test_reset_mid_filter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mist1032isa_sync_edge_detector.md
Name: mist1032isa_sync_edge_detector

Overview:
- Multi-channel edge-event detector for asynchronous UART/peripheral control lines (e.g. RX line, CTS, break detection).
- Per channel, in order: metastability synchroniser, stability filter (debounce), runtime-selectable edge qualifier (rise/fall/both/off), single-cycle event pulse, and a sticky pending/overrun flag pair with a software clear.
- Replaces the bare rising-edge pulse generator in the UART path.

Parameters:
- N, 1: number of independent channels.
- SYNC_STAGES, 2: synchroniser flip-flop depth. Legal range is 2..4; other values are a config error.
- FILTER_CYCLES, 1: consecutive cycles the synchronised value must differ from the filtered level before the filtered level flips. Legal range is 1..255; 1 means no filtering.
- INIT, {N{1'b0}}: reset value of the synchroniser stages and of the filtered level, per channel.

Ports:
- iCLOCK  in  1  single clock.
- inRESET  in  1  reset, synchronous, active-low.
- iSIGNAL  in  N  asynchronous raw inputs.
- iMODE  in  2N  per-channel mode; channel i uses bits [2i+1:2i]. 00 = off, 01 = rising, 10 = falling, 11 = both.
- iCLEAR  in  N  per-channel clear of the pending and overrun flags; level-sensitive, sampled each clock.
- oLEVEL  out  N  filtered, synchronised level.
- oPULSE  out  N  one-cycle event strobe.
- oPENDING  out  N  sticky event flag.
- oOVERRUN  out  N  sticky flag: an event arrived while the pending flag was already set.

Behaviour:
- One clock domain (iCLOCK); reset is synchronous and active-low (inRESET). All state changes on the rising edge of iCLOCK only.
- Reset (inRESET=0 at a clock edge):
  - synchroniser stages and oLEVEL are set to INIT;
  - filter counters are set to 0;
  - oPULSE, oPENDING and oOVERRUN are set to 0.
  - Reset overrides every other input. A reset in the middle of filtering discards the partial count.
- Synchroniser: sync[0] <= iSIGNAL, then sync[k] <= sync[k-1]; s = sync[SYNC_STAGES-1]. No combinational path from iSIGNAL to any output.
- Filter, per channel, counter width clog2(FILTER_CYCLES+1):
  - If s == oLEVEL: the counter is set to 0.
  - Else if counter == FILTER_CYCLES-1: oLEVEL <= s and the counter is set to 0.
  - Else: the counter increments.
  - A glitch shorter than FILTER_CYCLES cycles (after synchronisation) never changes oLEVEL.
  - The counter never exceeds FILTER_CYCLES-1.
- Event generation:
  - ev_i is true on the edge where oLEVEL flips, qualified by the channel's mode.
  - Rising flip (0->1) counts only in modes 01 and 11; falling flip (1->0) counts only in modes 10 and 11.
  - oPULSE <= ev, so oPULSE is high for exactly one cycle per qualified flip.
  - Mode is sampled on the same edge as the flip. Mode 00 suppresses pulses, but oLEVEL keeps tracking.
  - Changing mode never generates an event by itself.
- Latency: iSIGNAL stable before edge k leads to oLEVEL and oPULSE changing at edge k+SYNC_STAGES+FILTER_CYCLES-1. With defaults that is 3 edges after first capture.
- Pending/overrun, per channel:
  - ev=1, pending=0: pending <= 1.
  - ev=1, pending=1, clear=0: overrun <= 1, pending stays 1.
  - ev=1, clear=1: pending <= 1, overrun <= 0 (event wins over clear; no overrun is flagged).
  - ev=0, clear=1: pending <= 0, overrun <= 0.
  - Otherwise both flags hold.
- Channels are fully independent; simultaneous events on several channels are all reported.
- Boundary case: when the input is held at ~INIT through reset, a qualified event fires after release, at the normal latency. This is intentional; software clears it.

Test Plan:
- Reset with INIT=0, iSIGNAL=0: all outputs 0. Raise iSIGNAL[0] (N=1, mode 01, defaults) before edge k -> oLEVEL=1 and a single oPULSE at edge k+2; oPENDING=1 from edge k+2; oOVERRUN=0.
- FILTER_CYCLES=4: a 3-cycle high glitch -> oLEVEL, oPULSE and oPENDING stay 0. A 4-cycle high -> oLEVEL rises at edge k+5, one pulse.
- Mode sweep on one channel, toggling 0->1->0: mode 01 gives 1 pulse (rise), 10 gives 1 pulse (fall), 11 gives 2 pulses, 00 gives 0 pulses while oLEVEL still toggles.
- Two qualified events with no clear between them -> oPENDING=1, oOVERRUN=1. iCLEAR=1 for one cycle -> both 0 on the next edge.
- iCLEAR asserted on the same edge as a new event -> oPENDING=1, oOVERRUN=0.
- N=4, different modes per channel, inRESET driven low mid-filter on channel 2 -> all channels return to INIT with no stray pulse. After release, channel 2's filter restarts from count 0.
